pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: cycles fetch is suppressed before interrupt vectoring (legal 1..15).
REQ-002 Parameter CNT_W, default 16: width of stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 d_src1, d_src2  input  3 each  decode-stage source register addresses.
REQ-006 d_src1_used, d_src2_used  input  1 each  decode instruction reads that source.
REQ-007 e_dst  input  3  execute-stage destination register address.
REQ-008 e_wb, e_mem_read  input  1 each  execute instruction writes back / is a load.
REQ-009 e_branch_taken  input  1  execute-stage branch/jump resolved taken.
REQ-010 m_mem_busy  input  1  memory stage needs another cycle.
REQ-011 int_req  input  1  level interrupt request.
REQ-012 pc_we  output  1  PC register write enable.
REQ-013 pc_sel  output  2  00 sequential, 01 branch target, 10 interrupt vector, 11 unused.
REQ-014 fd_we, fd_flush  output  1 each  IF/ID register enable / clear to NOP.
REQ-015 de_we, de_bubble  output  1 each  ID/EX register enable / load NOP instead of decode.
REQ-016 em_we  output  1  EX/MEM register enable.
REQ-017 int_ack  output  1  one-cycle interrupt acknowledge.
REQ-018 stall_cnt  output  CNT_W  count of cycles with pc_we=0, saturating at all-ones.

Function
REQ-019 FSM states SHALL be RUN, INT_DRAIN, INT_VEC; outputs combinational from state and inputs; no input-to-state path other than listed transitions.
REQ-020 Default outputs (RUN, no event): pc_we=1, pc_sel=00, fd_we=1, de_we=1, em_we=1, all flush/bubble/ack=0.
REQ-021 Load-use hazard SHALL be e_mem_read & e_wb & ((d_src1_used & d_src1==e_dst) | (d_src2_used & d_src2==e_dst)).
REQ-022 Event priority, highest first: m_mem_busy, e_branch_taken, load-use, interrupt entry.
REQ-023 m_mem_busy=1 (any state): pc_we=fd_we=de_we=em_we=0, no flush/bubble, FSM state and drain counter frozen.
REQ-024 e_branch_taken=1 (mem not busy): pc_we=1, pc_sel=01, fd_flush=1, de_bubble=1; load-use ignored that cycle.
REQ-025 Load-use (no higher event): pc_we=0, fd_we=0, de_bubble=1 for exactly that cycle; next cycle load is in MEM and forwarding resolves it.
REQ-026 RUN->INT_DRAIN when int_req=1 and no mem-busy, branch or load-use event that cycle; drain counter loaded with DRAIN_CYCLES-1.
REQ-027 INT_DRAIN: pc_we=0, fd_flush=1, de_bubble=0; counter decrements each non-frozen cycle; ->INT_VEC when counter=0.
REQ-028 Branch taken during INT_DRAIN: fd_flush=1, de_bubble=1, pc_we=0 (target discarded, vector wins); drain continues.
REQ-029 INT_VEC: pc_we=1, pc_sel=10, fd_flush=1, int_ack=1 for one cycle, ->RUN; int_req deasserted by then is not re-sampled here.
REQ-030 int_req held after int_ack SHALL re-enter INT_DRAIN only from RUN on a later cycle (minimum one RUN cycle between acks).
REQ-031 stall_cnt increments by 1 each cycle pc_we=0, holds at 2^CNT_W-1.

Reset
REQ-032 rst=0 SHALL immediately force state RUN, drain counter 0, stall_cnt 0, independent of clk, including mid-drain or mid-vector.
REQ-033 During reset outputs SHALL equal REQ-020 defaults with int_ack=0; first post-reset edge evaluates inputs normally.

Verification
REQ-034 e_mem_read=1,e_wb=1,e_dst=3,d_src2=3,d_src2_used=1 one cycle -> pc_we=0,fd_we=0,de_bubble=1 that cycle only; stall_cnt 0->1.
REQ-035 Same load-use plus e_branch_taken=1 -> pc_sel=01,fd_flush=1,de_bubble=1,pc_we=1; stall_cnt unchanged.
REQ-036 m_mem_busy=1 for 4 cycles with load-use present -> all enables 0 for 4 cycles, stall_cnt +4, then load-use stall applies on cycle 5.
REQ-037 int_req=1 in RUN, DRAIN_CYCLES=3 -> 3 cycles pc_we=0,fd_flush=1, then 1 cycle pc_sel=10,int_ack=1, then RUN; stall_cnt +3.
REQ-038 rst=0 asserted in 2nd INT_DRAIN cycle -> state RUN, stall_cnt=0 asynchronously; no int_ack after release with int_req=0.
REQ-039 stall_cnt preloaded near max (CNT_W=4, 15 stall cycles then 2 more) -> holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-busy freeze, branch flush, load-use stall
// and interrupt entry (drain -> vector), plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       d_src1,
  input  logic [2:0]       d_src2,
  input  logic             d_src1_used,
  input  logic             d_src2_used,
  input  logic [2:0]       e_dst,
  input  logic             e_wb,
  input  logic             e_mem_read,
  input  logic             e_branch_taken,
  input  logic             m_mem_busy,
  input  logic             int_req,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             fd_we,
  output logic             fd_flush,
  output logic             de_we,
  output logic             de_bubble,
  output logic             em_we,
  output logic             int_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_INT_DRAIN = 2'd1,
    ST_INT_VEC   = 2'd2
  } state_e;

  localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use;

  assign load_use = e_mem_read & e_wb &
                    ((d_src1_used & (d_src1 == e_dst)) |
                     (d_src2_used & (d_src2 == e_dst)));

  // Outputs are combinational from state and inputs; reset forces the RUN defaults.
  always_comb begin
    pc_we     = 1'b1;
    pc_sel    = 2'b00;
    fd_we     = 1'b1;
    fd_flush  = 1'b0;
    de_we     = 1'b1;
    de_bubble = 1'b0;
    em_we     = 1'b1;
    int_ack   = 1'b0;
    state_d   = state_q;
    drain_d   = drain_q;
    if (!rst) begin
      state_d = ST_RUN;
    end else if (m_mem_busy) begin
      pc_we = 1'b0;
      fd_we = 1'b0;
      de_we = 1'b0;
      em_we = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (e_branch_taken) begin
            pc_sel    = 2'b01;
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
          end else if (load_use) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            de_bubble = 1'b1;
          end else if (int_req) begin
            state_d = ST_INT_DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end
        ST_INT_DRAIN: begin
          // A taken branch here is discarded: the interrupt vector wins.
          pc_we     = 1'b0;
          fd_flush  = 1'b1;
          de_bubble = e_branch_taken;
          if (drain_q == 4'd0) state_d = ST_INT_VEC;
          else                 drain_d = drain_q - 4'd1;
        end
        ST_INT_VEC: begin
          pc_sel   = 2'b10;
          fd_flush = 1'b1;
          int_ack  = 1'b1;
          state_d  = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
    stall_d = (!pc_we && (stall_q != {CNT_W{1'b1}})) ? stall_q + CNT_ONE : stall_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      drain_q <= 4'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed pinning sequences followed by
// randomized traffic checked every cycle against a phase/remaining-count model.
module tb_pipeline_hazard_ctrl;
  localparam int DRAIN = 3;
  localparam int CW    = 4;
  localparam int MAXS  = (1 << CW) - 1;
  // Packed output vector: {pc_we, pc_sel, fd_we, fd_flush, de_we, de_bubble, em_we, int_ack}
  localparam logic [8:0] V_DEF   = 9'b1_00_1_0_1_0_1_0;
  localparam logic [8:0] V_LU    = 9'b0_00_0_0_1_1_1_0;
  localparam logic [8:0] V_BR    = 9'b1_01_1_1_1_1_1_0;
  localparam logic [8:0] V_BUSY  = 9'b0_00_0_0_0_0_0_0;
  localparam logic [8:0] V_DRAIN = 9'b0_00_1_1_1_0_1_0;
  localparam logic [8:0] V_VEC   = 9'b1_10_1_1_1_0_1_1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] d_src1 = '0, d_src2 = '0, e_dst = '0;
  logic d_src1_used = 0, d_src2_used = 0, e_wb = 0, e_mem_read = 0;
  logic e_branch_taken = 0, m_mem_busy = 0, int_req = 0;
  logic pc_we, fd_we, fd_flush, de_we, de_bubble, em_we, int_ack;
  logic [1:0] pc_sel, dbg_state;
  logic [CW-1:0] stall_cnt;
  logic [8:0] dut_vec;

  int total = 0;
  int bad   = 0;

  // model state: phase 0 = running, 1 = draining (rem cycles left incl. current), 2 = vectoring
  int m_phase = 0;
  int m_rem   = 0;
  int m_stall = 0;
  logic [8:0] m_ev;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .d_src1(d_src1), .d_src2(d_src2),
    .d_src1_used(d_src1_used), .d_src2_used(d_src2_used),
    .e_dst(e_dst), .e_wb(e_wb), .e_mem_read(e_mem_read),
    .e_branch_taken(e_branch_taken), .m_mem_busy(m_mem_busy), .int_req(int_req),
    .pc_we(pc_we), .pc_sel(pc_sel), .fd_we(fd_we), .fd_flush(fd_flush),
    .de_we(de_we), .de_bubble(de_bubble), .em_we(em_we), .int_ack(int_ack),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  assign dut_vec = {pc_we, pc_sel, fd_we, fd_flush, de_we, de_bubble, em_we, int_ack};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    d_src1 = '0; d_src2 = '0; e_dst = '0;
    d_src1_used = 0; d_src2_used = 0; e_wb = 0; e_mem_read = 0;
    e_branch_taken = 0; m_mem_busy = 0; int_req = 0;
  endtask

  task automatic set_load_use();
    e_mem_read = 1; e_wb = 1; e_dst = 3'd3; d_src2 = 3'd3; d_src2_used = 1;
    d_src1 = 3'd5; d_src1_used = 1;
  endtask

  // Reference model and per-cycle compare, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    logic lu, pw, fw, fl, dw, bb, ew, ak;
    logic [1:0] ps;
    if (!rst) begin
      m_phase = 0; m_rem = 0; m_stall = 0;
      exp_q.push_back(V_DEF);
      chk("rst_vec", 32'(dut_vec), 32'(exp_q.pop_front()));
      chk("rst_stall", 32'(stall_cnt), 32'(m_stall));
    end else begin
      lu = e_mem_read && e_wb &&
           ((d_src1_used && d_src1 == e_dst) || (d_src2_used && d_src2 == e_dst));
      pw = 1; ps = 2'b00; fw = 1; fl = 0; dw = 1; bb = 0; ew = 1; ak = 0;
      if (m_mem_busy) begin
        pw = 0; fw = 0; dw = 0; ew = 0;
      end else if (m_phase == 0) begin
        if (e_branch_taken) begin ps = 2'b01; fl = 1; bb = 1; end
        else if (lu)        begin pw = 0; fw = 0; bb = 1; end
      end else if (m_phase == 1) begin
        pw = 0; fl = 1; bb = e_branch_taken;
      end else begin
        ps = 2'b10; fl = 1; ak = 1;
      end
      m_ev = {pw, ps, fw, fl, dw, bb, ew, ak};
      exp_q.push_back(m_ev);
      chk("cyc_vec", 32'(dut_vec), 32'(exp_q.pop_front()));
      chk("cyc_stall", 32'(stall_cnt), 32'(m_stall));
      if (!m_mem_busy) begin
        if (m_phase == 0) begin
          if (!e_branch_taken && !lu && int_req) begin m_phase = 1; m_rem = DRAIN; end
        end else if (m_phase == 1) begin
          if (m_rem == 1) m_phase = 2;
          else m_rem = m_rem - 1;
        end else begin
          m_phase = 0;
        end
      end
      if (!pw && m_stall < MAXS) m_stall = m_stall + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 0;
    #2;
    chk("reset_vec", 32'(dut_vec), 32'(V_DEF));
    chk("reset_stall", 32'(stall_cnt), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    m_mem_busy = 1;
    #1;
    chk("reset_busy_masked", 32'(dut_vec), 32'(V_DEF));
    m_mem_busy = 0;
    cyc(); cyc();
    rst = 1;
    cyc();

    // single load-use cycle
    set_load_use();
    #1 chk("lu_vec", 32'(dut_vec), 32'(V_LU));
    cyc(); clear_inputs();
    #1 chk("lu_after_vec", 32'(dut_vec), 32'(V_DEF));
    chk("lu_stall", 32'(stall_cnt), 32'd1);

    // load-use with branch: branch wins
    cyc(); set_load_use(); e_branch_taken = 1;
    #1 chk("br_lu_vec", 32'(dut_vec), 32'(V_BR));
    cyc(); clear_inputs();
    #1 chk("br_lu_stall", 32'(stall_cnt), 32'd1);

    // memory busy for 4 cycles over a pending load-use
    set_load_use(); m_mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("busy_vec", 32'(dut_vec), 32'(V_BUSY));
      cyc();
    end
    m_mem_busy = 0;
    #1 chk("busy_then_lu_vec", 32'(dut_vec), 32'(V_LU));
    chk("busy_stall", 32'(stall_cnt), 32'd5);
    cyc(); clear_inputs();
    #1 chk("busy_lu_stall", 32'(stall_cnt), 32'd6);

    // interrupt entry: one RUN cycle, three drain cycles, one vector cycle
    int_req = 1;
    #1 chk("int_entry_vec", 32'(dut_vec), 32'(V_DEF));
    cyc(); int_req = 0;
    for (int i = 0; i < DRAIN; i++) begin
      #1 chk("int_drain_vec", 32'(dut_vec), 32'(V_DRAIN));
      cyc();
    end
    #1 chk("int_vec_vec", 32'(dut_vec), 32'(V_VEC));
    cyc();
    #1 chk("int_back_vec", 32'(dut_vec), 32'(V_DEF));
    chk("int_stall", 32'(stall_cnt), 32'd9);

    // async reset in the 2nd drain cycle
    int_req = 1;
    cyc(); int_req = 0;
    cyc();
    #1 chk("drain2_vec", 32'(dut_vec), 32'(V_DRAIN));
    rst = 0;
    #1 chk("async_stall", 32'(stall_cnt), 32'd0);
    chk("async_state", 32'(dbg_state), 32'd0);
    chk("async_vec", 32'(dut_vec), 32'(V_DEF));
    cyc(); rst = 1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("post_rst_no_ack", 32'(int_ack), 32'd0);
      cyc();
    end

    // saturation of the 4-bit stall counter
    m_mem_busy = 1;
    for (int i = 0; i < 15; i++) cyc();
    #1 chk("sat_reach", 32'(stall_cnt), 32'd15);
    cyc(); cyc();
    #1 chk("sat_hold", 32'(stall_cnt), 32'd15);
    m_mem_busy = 0;

    // randomized traffic, including held interrupt requests and rare resets
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst            = ($urandom_range(0, 199) != 0);
      d_src1         = 3'($urandom_range(0, 3));
      d_src2         = 3'($urandom_range(0, 3));
      e_dst          = 3'($urandom_range(0, 3));
      d_src1_used    = 1'($urandom_range(0, 1));
      d_src2_used    = 1'($urandom_range(0, 1));
      e_wb           = ($urandom_range(0, 3) != 0);
      e_mem_read     = ($urandom_range(0, 2) == 0);
      e_branch_taken = ($urandom_range(0, 6) == 0);
      m_mem_busy     = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) int_req = ~int_req;
    end
    cyc();
    rst = 1;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
